// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder slice.
// Imported by mem_array and mem_responder.
package mem_pkg;

  localparam int MEM_WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP,
    DONE
  } mem_state_e;

  typedef enum logic [1:0] {
    READ,
    WRITE,
    BAD
  } mem_op_e;

endpackage

// File: rtl/mem_array.sv
// Single-port word storage: synchronous read into an output register,
// synchronous write. Contents are never reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [MEM_WORD_W-1:0] wdata,
  output logic [MEM_WORD_W-1:0] rdata
);

  logic [MEM_WORD_W-1:0] mem [2**ADDR_WIDTH];

  // One access per enabled cycle: write the word, or latch it into rdata.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: captures one CPU request at a time, optionally inserts
// wait states, accesses mem_array, then pulses ready for one cycle.
// Optional feature macro: MEM_WAIT_STATES_EN (wait-state counter and WAIT
// state); without it every request goes straight from IDLE to ACCESS.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  input  logic                  mem_rd,
  input  logic                  mem_wr,
  output tri   [MEM_WORD_W-1:0] rdata,
  output logic                  ready,
  output logic                  err
);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15 || ADDR_WIDTH < 1 || ADDR_WIDTH > 31) begin : g_param_check
    $error("mem_responder: WAIT_CYCLES must be 0..15 and ADDR_WIDTH 1..31");
  end

  mem_state_e            state;
  mem_op_e               hold_op;
  logic [ADDR_WIDTH-1:0] hold_addr;
  logic [31:0]           hold_wdata;
  logic                  rd_drive;
  logic [31:0]           arr_rdata;

  logic                  req;
  logic                  addr_oob;
  mem_op_e               req_op;
  logic                  arr_en;
  logic                  arr_we;

`ifdef MEM_WAIT_STATES_EN
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  logic [3:0] cnt;
`endif

  assign req      = mem_rd | mem_wr;
  assign addr_oob = (addr >> ADDR_WIDTH) != 32'd0;

  // Classify the request on the bus; conflicting strobes or an address
  // beyond the array both become a rejected (BAD) request.
  always_comb begin
    req_op = WRITE;
    if ((mem_rd && mem_wr) || addr_oob) begin
      req_op = BAD;
    end else if (mem_rd) begin
      req_op = READ;
    end
  end

  // The array is touched only in ACCESS and never for a rejected request.
  assign arr_en = (state == ACCESS) && (hold_op != BAD);
  assign arr_we = (hold_op == WRITE);

  // Read data is released to high-Z except during a read response.
  assign rdata = rd_drive ? arr_rdata : {MEM_WORD_W{1'bz}};

  mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk  (clk),
    .en   (arr_en),
    .we   (arr_we),
    .addr (hold_addr),
    .wdata(hold_wdata),
    .rdata(arr_rdata)
  );

  // Request FSM with registered ready/err/rdata-enable outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      hold_op    <= READ;
      hold_addr  <= '0;
      hold_wdata <= '0;
      ready      <= 1'b0;
      err        <= 1'b0;
      rd_drive   <= 1'b0;
`ifdef MEM_WAIT_STATES_EN
      cnt        <= 4'd0;
`endif
    end else begin
      ready    <= 1'b0;
      err      <= 1'b0;
      rd_drive <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            hold_addr  <= addr[ADDR_WIDTH-1:0];
            hold_wdata <= wdata;
            hold_op    <= req_op;
`ifdef MEM_WAIT_STATES_EN
            if (WAIT_CYCLES > 0) begin
              state <= WAIT;
              cnt   <= WAIT_LOAD;
            end else begin
              state <= ACCESS;
            end
`else
            state <= ACCESS;
`endif
          end
        end
`ifdef MEM_WAIT_STATES_EN
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= ACCESS;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
`endif
        ACCESS: begin
          state <= RESP;
        end
        RESP: begin
          ready    <= 1'b1;
          err      <= (hold_op == BAD);
          rd_drive <= (hold_op == READ);
          state    <= DONE;
        end
        DONE: begin
          // Wait for the CPU to drop its strobes so a held request is
          // not serviced a second time.
          if (!req) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized
// requests, checked every cycle against a transaction-level model.
module tb_mem_responder;

  localparam int ADDR_WIDTH  = 10;
  localparam int WAIT_CYCLES = 2;
`ifdef MEM_WAIT_STATES_EN
  localparam int LAT     = WAIT_CYCLES + 2;
  localparam int LAT_LIT = 4;
`else
  localparam int LAT     = 2;
  localparam int LAT_LIT = 2;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_rd;
  logic        mem_wr;
  tri0  [31:0] rdata;
  logic        ready;
  logic        err;

  mem_responder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .wdata (wdata),
    .mem_rd(mem_rd),
    .mem_wr(mem_wr),
    .rdata (rdata),
    .ready (ready),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          exp_cyc = -1;
  int          cap_cyc = 0;
  logic        exp_err = 1'b0;
  logic        exp_drv = 1'b0;
  logic [31:0] exp_data = 32'd0;
  logic [31:0] mdl [16];
  int          rdy_count = 0;
  int          last_rdy_cyc = 0;
  logic [31:0] last_rdata = 32'd0;
  logic        last_err = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, got, expv);
    end
  endtask

  // Per-cycle compare against the transaction model (sampled after the edge).
  always @(posedge clk) begin
    cyc++;
    #2;
    if (!rst) begin
      chk("rst_ready", {31'd0, ready}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
    end else begin
      logic exp_rdy;
      exp_rdy = (cyc == exp_cyc);
      chk("ready", {31'd0, ready}, {31'd0, exp_rdy});
      chk("err", {31'd0, err}, {31'd0, exp_rdy && exp_err});
      chk("rdata", rdata, (exp_rdy && exp_drv) ? exp_data : 32'd0);
      if (ready) begin
        rdy_count++;
        last_rdy_cyc = cyc;
        last_rdata   = rdata;
        last_err     = err;
      end
    end
  end

  // Issue one request, update the model, and drive until the bus is idle again.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input int hold, input bit scramble);
    logic bad;
    @(negedge clk);
    addr   = a;
    wdata  = wd;
    mem_rd = rd;
    mem_wr = wr;
    bad      = (rd && wr) || ((a >> ADDR_WIDTH) != 32'd0);
    exp_err  = bad;
    exp_drv  = !bad && rd;
    exp_data = 32'd0;
    if (!bad && rd) exp_data = mdl[a[3:0]];
    if (!bad && wr) mdl[a[3:0]] = wd;
    cap_cyc = cyc + 1;
    exp_cyc = cap_cyc + LAT;
    while (cyc < exp_cyc) begin
      @(negedge clk);
      if (cyc < exp_cyc && scramble) begin
        addr   = $urandom;
        wdata  = $urandom;
        mem_rd = 1'($urandom);
        mem_wr = 1'($urandom);
      end
    end
    mem_rd = (hold > 0) ? rd : 1'b0;
    mem_wr = (hold > 0) ? wr : 1'b0;
    repeat (hold) @(negedge clk);
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int r0;
    rst    = 1'b0;
    addr   = 32'd0;
    wdata  = 32'd0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Known contents for the words used by the bench.
    for (int i = 0; i < 16; i++) begin
      do_req(1'b0, 1'b1, 32'(i), 32'hA500_0000 | 32'(i), 0, 1'b0);
    end

    // Write then read back 0x5.
    do_req(1'b0, 1'b1, 32'h5, 32'hDEADBEEF, 0, 1'b0);
    chk("wr5_latency", 32'(last_rdy_cyc - cap_cyc), 32'(LAT_LIT));
    chk("wr5_err", {31'd0, last_err}, 32'd0);
    do_req(1'b1, 1'b0, 32'h5, 32'h0, 0, 1'b1);
    chk("rd5_latency", 32'(last_rdy_cyc - cap_cyc), 32'(LAT_LIT));
    chk("rd5_data", last_rdata, 32'hDEADBEEF);

    // Held read: a single response only.
    r0 = rdy_count;
    do_req(1'b1, 1'b0, 32'h5, 32'h0, 7, 1'b0);
    chk("held_rd_pulses", 32'(rdy_count - r0), 32'd1);

    // Conflicting strobes at 0x3, then confirm the word is untouched.
    do_req(1'b1, 1'b1, 32'h3, 32'hFFFF_0000, 0, 1'b0);
    chk("both_err", {31'd0, last_err}, 32'd1);
    do_req(1'b1, 1'b0, 32'h3, 32'h0, 0, 1'b0);
    chk("rd3_data", last_rdata, 32'hA500_0003);

    // Out-of-range read and write alias onto word 0 but must not touch it.
    do_req(1'b1, 1'b0, 32'h400, 32'h0, 0, 1'b0);
    chk("oob_rd_err", {31'd0, last_err}, 32'd1);
    do_req(1'b0, 1'b1, 32'h400, 32'h1111_2222, 0, 1'b0);
    chk("oob_wr_err", {31'd0, last_err}, 32'd1);
    do_req(1'b1, 1'b0, 32'h0, 32'h0, 0, 1'b0);
    chk("rd0_data", last_rdata, 32'hA500_0000);

    // Write to 0x7 aborted by reset before the array is touched.
    r0 = rdy_count;
    @(negedge clk);
    addr   = 32'h7;
    wdata  = 32'h1234_5678;
    mem_wr = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    exp_cyc = -1;
    mem_wr  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (LAT + 2) @(negedge clk);
    chk("abort_no_ready", 32'(rdy_count - r0), 32'd0);
    do_req(1'b1, 1'b0, 32'h7, 32'h0, 0, 1'b0);
    chk("rd7_data", last_rdata, 32'hA500_0007);

    // Randomized traffic.
    for (int n = 0; n < 80; n++) begin
      int          kind;
      logic [31:0] a;
      kind = int'($urandom_range(0, 9));
      a    = 32'($urandom_range(0, 15));
      if (kind == 9) a = (32'($urandom_range(1, 4000)) << ADDR_WIDTH) | a;
      case (kind)
        0, 1, 2, 3: do_req(1'b1, 1'b0, a, $urandom, int'($urandom_range(0, 3)), 1'($urandom));
        4, 5, 6, 7: do_req(1'b0, 1'b1, a, $urandom, int'($urandom_range(0, 3)), 1'($urandom));
        8:          do_req(1'b1, 1'b1, a, $urandom, int'($urandom_range(0, 2)), 1'($urandom));
        default:    do_req(1'($urandom), 1'b1, a, $urandom, 0, 1'($urandom));
      endcase
    end

    // Final sweep reads every word back through the model.
    for (int i = 0; i < 16; i++) begin
      do_req(1'b1, 1'b0, 32'(i), 32'h0, 0, 1'b0);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
